// File: rtl/scfifo_flex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scfifo_flex
// Brief    : Single-clock FIFO with arbitrary depth, normal/show-ahead read,
//            almost-full/empty thresholds, sync clear and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module scfifo_flex #(
  parameter int    lpm_width          = 8,
  parameter int    lpm_numwords       = 16,
  parameter int    lpm_widthu         = 4,
  parameter string lpm_showahead      = "OFF",
  parameter int    almost_full_value  = 12,
  parameter int    almost_empty_value = 4
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic [lpm_widthu:0]   usedw,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [lpm_widthu-1:0] LAST_PTR = lpm_widthu'(lpm_numwords - 1);
  localparam logic [lpm_widthu-1:0] PTR_ONE  = lpm_widthu'(1);
  localparam logic [lpm_widthu:0]   DEPTH    = (lpm_widthu + 1)'(lpm_numwords);
  localparam logic [lpm_widthu:0]   CNT_ONE  = (lpm_widthu + 1)'(1);

  logic [lpm_width-1:0]  r_mem [0:lpm_numwords-1];
  logic [lpm_widthu-1:0] r_wr_ptr;
  logic [lpm_widthu-1:0] r_rd_ptr;
  logic [lpm_widthu:0]   r_usedw;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [lpm_widthu-1:0] w_wr_ptr_nxt;
  logic [lpm_widthu-1:0] w_rd_ptr_nxt;

  assign w_empty = (r_usedw == '0);
  assign w_full  = (r_usedw == DEPTH);
  assign w_rd_ok = rdreq && !w_empty;
  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign w_wr_ok = wrreq && (!w_full || w_rd_ok);

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_usedw     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_usedw     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_ok) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_usedw <= r_usedw + CNT_ONE;
        2'b01:   r_usedw <= r_usedw - CNT_ONE;
        default: r_usedw <= r_usedw;
      endcase
      if (wrreq && !w_wr_ok) r_overflow  <= 1'b1;
      if (rdreq && !w_rd_ok) r_underflow <= 1'b1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (w_wr_ok && !sclr) r_mem[r_wr_ptr] <= data;
  end

  generate
    if (lpm_showahead == "ON") begin : g_showahead
      assign q = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_normal
      logic [lpm_width-1:0] r_q;
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)      r_q <= '0;
        else if (sclr)    r_q <= '0;
        else if (w_rd_ok) r_q <= r_mem[r_rd_ptr];
      end
      assign q = r_q;
    end
  endgenerate

  assign usedw        = r_usedw;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (int'(r_usedw) >= almost_full_value);
  assign almost_empty = (int'(r_usedw) <  almost_empty_value);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire
